// File: rtl/seq_debounce_8b.sv
// seq_debounce_8b: 8-lane input conditioner. Each raw input passes through a
// two-flop synchronizer and a per-lane stability counter; the registered
// output only follows a lane once it has disagreed with the current output
// for STABLE_CYCLES consecutive edges. A one-cycle `changed` pulse marks
// every output toggle.
module seq_debounce_8b #(
  parameter  int unsigned STABLE_CYCLES = 4,
  localparam int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,    // asynchronous, active-low
  input  logic       clear,    // synchronous, abandons pending transitions
  input  logic [7:0] in_,
  output logic [7:0] out,
  output logic [7:0] changed
);

  localparam int unsigned          LANES   = 8;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       out_q, out_d;
  logic [7:0]       changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [LANES];
  logic [CNT_W-1:0] cnt_d [LANES];

  // Two-flop synchronizer per lane; nothing sits between the flops so each
  // stage has a full cycle to resolve metastability.
  // NOTE: registered state is always written with <= so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // chain into a single stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_;
      sync2_q <= sync1_q;
    end
  end

  // Per-lane filter decision: clear, agree, commit, or keep counting.
  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a variable unassigned and no latch can be inferred.
  always_comb begin
    out_d     = out_q;
    changed_d = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < LANES; i++) begin
      if (clear) begin
        cnt_d[i] = '0;
      end else if (sync2_q[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        out_d[i]     = sync2_q[i];
        cnt_d[i]     = '0;
        changed_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Filter state registers: debounced level, toggle pulse, stability counts.
  // NOTE: the counter array is only eight small registers, not a RAM, so it
  // is cleared by reset like any other flop; a stale count after reset would
  // let a lane commit early.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      changed_q <= '0;
      for (int i = 0; i < LANES; i++) cnt_q[i] <= '0;
    end else begin
      out_q     <= out_d;
      changed_q <= changed_d;
      for (int i = 0; i < LANES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out     = out_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_seq_debounce_8b.sv
// Directed self-checking bench for seq_debounce_8b with STABLE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. after the edge has settled and well before the next one.
module tb_seq_debounce_8b;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [7:0] in_;
  logic [7:0] out;
  logic [7:0] changed;

  int checks = 0;
  int errors = 0;

  seq_debounce_8b #(.STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .in_     (in_),
    .out     (out),
    .changed (changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and step past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear = 1'b0;
    in_   = 8'h00;
    #3;
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL reset_out got %h want 00", out);
    end
    checks++;
    if (changed !== 8'h00) begin
      errors++;
      $display("FAIL reset_changed got %h want 00", changed);
    end
    tick();
    tick();
    reset = 1'b1;
  endtask

  // 00 for four cycles, then 01 held: out follows after edge 6.
  task automatic test_clean_step();
    in_ = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (out !== 8'h00 || changed !== 8'h00) begin
        errors++;
        $display("FAIL step_idle cyc %0d out %h changed %h want 00/00", k, out, changed);
      end
    end
    in_ = 8'h01;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (out !== 8'h00 || changed !== 8'h00) begin
        errors++;
        $display("FAIL step_wait edge %0d out %h changed %h want 00/00", e, out, changed);
      end
    end
    tick();
    checks++;
    if (out !== 8'h01 || changed !== 8'h01) begin
      errors++;
      $display("FAIL step_commit out %h changed %h want 01/01", out, changed);
    end
    tick();
    checks++;
    if (out !== 8'h01 || changed !== 8'h00) begin
      errors++;
      $display("FAIL step_pulse_end out %h changed %h want 01/00", out, changed);
    end
  endtask

  // Drive a held value and expect a commit on exactly edge 6.
  task automatic settle(input logic [7:0] from_v, input logic [7:0] to_v,
                        input logic [7:0] pulse_v, input string name);
    in_ = to_v;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (out !== from_v || changed !== 8'h00) begin
        errors++;
        $display("FAIL %s_wait edge %0d out %h changed %h want %h/00", name, e, out, changed, from_v);
      end
    end
    tick();
    checks++;
    if (out !== to_v || changed !== pulse_v) begin
      errors++;
      $display("FAIL %s_commit out %h changed %h want %h/%h", name, out, changed, to_v, pulse_v);
    end
  endtask

  // Three-cycle glitch is the longest pulse that must still be rejected.
  task automatic test_glitch();
    settle(8'h01, 8'h00, 8'h01, "fall");
    in_ = 8'h01;
    tick();
    tick();
    tick();
    in_ = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (out !== 8'h00 || changed !== 8'h00) begin
        errors++;
        $display("FAIL glitch cyc %0d out %h changed %h want 00/00", k, out, changed);
      end
    end
  endtask

  // Single-cycle bounces earn no credit; count restarts at the last rise.
  task automatic test_bounce();
    logic [7:0] pat [6];
    pat = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
    for (int k = 0; k < 6; k++) begin
      in_ = pat[k];
      tick();
      checks++;
      if (out !== 8'h00 || changed !== 8'h00) begin
        errors++;
        $display("FAIL bounce_seq cyc %0d out %h changed %h want 00/00", k, out, changed);
      end
    end
    for (int e = 2; e <= 5; e++) begin
      tick();
      checks++;
      if (out !== 8'h00 || changed !== 8'h00) begin
        errors++;
        $display("FAIL bounce_wait edge %0d out %h changed %h want 00/00", e, out, changed);
      end
    end
    tick();
    checks++;
    if (out !== 8'h01 || changed !== 8'h01) begin
      errors++;
      $display("FAIL bounce_commit out %h changed %h want 01/01", out, changed);
    end
    tick();
    checks++;
    if (changed !== 8'h00) begin
      errors++;
      $display("FAIL bounce_pulse_end changed %h want 00", changed);
    end
  endtask

  task automatic test_multi_lane();
    settle(8'h01, 8'h00, 8'h01, "ml_prep");
    settle(8'h00, 8'hAA, 8'hAA, "ml_aa");
    settle(8'hAA, 8'h55, 8'hFF, "ml_55");
  endtask

  // Clear on edges 4..6 wipes progress; four more edges needed afterwards.
  task automatic test_clear();
    settle(8'h55, 8'h00, 8'h55, "clr_prep");
    in_ = 8'h11;
    for (int e = 1; e <= 6; e++) begin
      if (e == 4) clear = 1'b1;
      tick();
      checks++;
      if (out !== 8'h00 || changed !== 8'h00) begin
        errors++;
        $display("FAIL clear_hold edge %0d out %h changed %h want 00/00", e, out, changed);
      end
    end
    clear = 1'b0;
    for (int e = 7; e <= 9; e++) begin
      tick();
      checks++;
      if (out !== 8'h00 || changed !== 8'h00) begin
        errors++;
        $display("FAIL clear_wait edge %0d out %h changed %h want 00/00", e, out, changed);
      end
    end
    tick();
    checks++;
    if (out !== 8'h11 || changed !== 8'h11) begin
      errors++;
      $display("FAIL clear_commit out %h changed %h want 11/11", out, changed);
    end
  endtask

  // Clear landing on the would-be commit edge suppresses update and pulse.
  task automatic test_clear_at_fire();
    in_ = 8'h00;
    for (int e = 1; e <= 5; e++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (out !== 8'h11 || changed !== 8'h00) begin
      errors++;
      $display("FAIL clrfire_block out %h changed %h want 11/00", out, changed);
    end
    for (int e = 7; e <= 9; e++) tick();
    checks++;
    if (out !== 8'h11) begin
      errors++;
      $display("FAIL clrfire_wait out %h want 11", out);
    end
    tick();
    checks++;
    if (out !== 8'h00 || changed !== 8'h11) begin
      errors++;
      $display("FAIL clrfire_commit out %h changed %h want 00/11", out, changed);
    end
  endtask

  // Reset dropped mid-cycle clears outputs before the next edge.
  task automatic test_async_reset();
    settle(8'h00, 8'hFF, 8'hFF, "ar_prep");
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out !== 8'h00 || changed !== 8'h00) begin
      errors++;
      $display("FAIL areset_immediate out %h changed %h want 00/00", out, changed);
    end
    tick();
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL areset_held out %h want 00", out);
    end
    reset = 1'b1;
    settle(8'h00, 8'hFF, 8'hFF, "ar_release");
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_multi_lane();
    test_clear();
    test_clear_at_fire();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
